// File: rtl/imem_stream_loader.sv
// Boot-time loader: assembles a big-endian byte stream into 32-bit words and writes them to instruction memory.
// Holds the core in reset until the image is loaded. Define IMEM_LOADER_CHECKSUM_EN to add a trailing XOR checksum byte.
module imem_stream_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 64
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [7:0]  in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic        imem_we_o,
    output logic [31:0] imem_addr_o,
    output logic [31:0] imem_wdata_o,
    output logic        cpu_reset_o,
    output logic        done_o,
    output logic        error_o,
    output logic [15:0] words_loaded_o
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_HDR_HI = 3'd0, S_HDR_LO = 3'd1, S_DATA = 3'd2,
        S_CHK = 3'd3, S_DONE = 3'd4, S_ERROR = 3'd5
    } state_t;
    localparam state_t S_FIN = S_CHK;
    logic [7:0] xor_q, xor_d;
`else
    typedef enum logic [2:0] {
        S_HDR_HI = 3'd0, S_HDR_LO = 3'd1, S_DATA = 3'd2,
        S_DONE = 3'd4, S_ERROR = 3'd5
    } state_t;
    localparam state_t S_FIN = S_DONE;
`endif

    localparam logic [31:0] MAX_W = MAX_WORDS;

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] idx_q, idx_d;
    logic [1:0]  lane_q, lane_d;
    logic [23:0] asm_q, asm_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [15:0] words_q, words_d;
    logic [15:0] hdr_n;
    logic        accept;

    assign in_ready_o = (state_q != S_DONE) && (state_q != S_ERROR);
    assign accept     = in_valid_i && in_ready_o;
    assign hdr_n      = {count_q[15:8], in_data_i};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_HDR_HI;
            count_q     <= '0;
            idx_q       <= '0;
            lane_q      <= '0;
            asm_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= BASE_ADDR;
            wdata_q     <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            words_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            lane_q      <= lane_d;
            asm_q       <= asm_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
            words_q     <= words_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q       <= xor_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        lane_d      = lane_q;
        asm_d       = asm_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        words_d     = words_q;
        cpu_reset_d = 1'b1;
        done_d      = 1'b0;
        error_d     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d       = xor_q;
        if (accept && (state_q != S_CHK)) xor_d = xor_q ^ in_data_i;
`endif
        case (state_q)
            S_HDR_HI: begin
                if (accept) begin
                    count_d[15:8] = in_data_i;
                    state_d       = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (accept) begin
                    count_d[7:0] = in_data_i;
                    if ({16'd0, hdr_n} > MAX_W) state_d = S_ERROR;
                    else if (hdr_n == 16'd0)    state_d = S_FIN;
                    else                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    if (lane_q == 2'd3) begin
                        wdata_d = {asm_q, in_data_i};
                        addr_d  = BASE_ADDR + {14'd0, idx_q, 2'b00};
                        we_d    = 1'b1;
                        idx_d   = idx_q + 16'd1;
                        words_d = words_q + 16'd1;
                        lane_d  = 2'd0;
                        if (idx_q == count_q - 16'd1) state_d = S_FIN;
                    end else begin
                        asm_d  = {asm_q[15:0], in_data_i};
                        lane_d = lane_q + 2'd1;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) state_d = (in_data_i == xor_q) ? S_DONE : S_ERROR;
            end
`endif
            S_DONE: begin
                done_d      = 1'b1;
                cpu_reset_d = 1'b0;
            end
            S_ERROR: begin
                error_d = 1'b1;
            end
            default: state_d = S_HDR_HI;
        endcase
        // restart only from a terminal state; memory contents are left as written
        if (start_i && ((state_q == S_DONE) || (state_q == S_ERROR))) begin
            state_d     = S_HDR_HI;
            done_d      = 1'b0;
            error_d     = 1'b0;
            cpu_reset_d = 1'b1;
            words_d     = '0;
            idx_d       = '0;
            lane_d      = '0;
            asm_d       = '0;
            count_d     = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_d       = '0;
`endif
        end
    end

    assign imem_we_o      = we_q;
    assign imem_addr_o    = addr_q;
    assign imem_wdata_o   = wdata_q;
    assign cpu_reset_o    = cpu_reset_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign words_loaded_o = words_q;

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Boot-time program loader sitting directly upstream of the instruction memory in the single-cycle MIPS core.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes the words into instruction memory starting at BASE_ADDR.
- Holds the datapath in reset until the image is fully written, then releases it.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; word aligned.
- MAX_WORDS, 64, maximum image size in words; must not exceed instruction-memory depth.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; restarts loading from DONE or ERROR, ignored in other states.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte; combinational from state.
- imem_we  output  1  instruction-memory write strobe, one-cycle pulse.
- imem_addr  output  32  byte address of the write.
- imem_wdata  output  32  assembled instruction word.
- cpu_reset  output  1  high while loading; drives the datapath reset.
- done  output  1  image loaded, core released.
- error  output  1  load failed; core stays in reset.
- words_loaded  output  16  count of words written in the current load.

Behaviour:
- A byte transfers on a rising edge when in_valid && in_ready.
- Stream format:
  - 2-byte word count N, high byte first.
  - Then N words, 4 bytes each, MSB first.
  - Then an optional checksum byte (see Optional Feature).
- FSM states: HDR_HI, HDR_LO, DATA, CHK, DONE, ERROR.
  - CHK exists only when the Optional Feature is compiled in.
  - in_ready=1 in HDR_HI, HDR_LO, DATA and CHK; in_ready=0 in DONE and ERROR.
- Reset (asynchronous, any state):
  - state=HDR_HI, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_reset=1, done=0, error=0, words_loaded=0.
  - Byte-lane and word-index counters clear.
- HDR_HI: accept byte -> count[15:8], go to HDR_LO.
- HDR_LO: accept byte -> count[7:0], then:
  - N > MAX_WORDS -> ERROR.
  - N == 0 -> DONE, or CHK if the feature is enabled.
  - Otherwise -> DATA.
- DATA:
  - Bytes shift into a 32-bit assembler, byte lane 0..3.
  - On the edge accepting lane 3:
    - imem_wdata <= {assembler[23:0], in_data}.
    - imem_addr <= BASE_ADDR + 4*idx.
    - imem_we <= 1.
    - idx and words_loaded increment.
  - imem_we returns to 0 on the next edge. Write latency is 1 cycle after the 4th byte; at most one write every 4 accepted bytes.
  - Address arithmetic is 32-bit, wrap ignored; BASE_ADDR + 4*MAX_WORDS is required not to overflow.
  - When the accepted word is word N-1, go to DONE (or CHK) on the same edge.
- DONE:
  - done=1 and cpu_reset=0, registered, starting the cycle after the final imem_we pulse.
  - In_data is never consumed here.
- ERROR: error=1, cpu_reset=1, done=0.
- start in DONE or ERROR:
  - Next edge: state=HDR_HI, cpu_reset=1, done=0, error=0, words_loaded=0, counters clear.
  - Memory contents are not cleared.
- start in any other state has no effect.
- in_valid low mid-word: the assembler holds its partial word indefinitely; there is no timeout.
- Reset mid-load aborts the load. Words already written stay in memory. cpu_reset reasserts immediately (asynchronously).
- start and reset asserted together: reset wins.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR is taken over every accepted header and data byte.
  - After the last word (or after the header when N=0), the FSM enters CHK and accepts one byte.
  - Byte equals the running XOR -> DONE; otherwise -> ERROR.
  - Words are already written either way.
- Undefined:
  - No CHK state and no XOR register; the FSM goes straight to DONE.
  - Any trailing byte is left unconsumed, since in_ready=0 in DONE.

Test Plan:
- Reset release, stream 00 02 20 08 00 05 8C 09 00 00, valid every cycle:
  - Pulse 1: imem_we with addr 0x0, data 0x20080005.
  - Pulse 2: imem_we with addr 0x4, data 0x8C090000.
  - Then done=1, cpu_reset=0, words_loaded=2.
- Header 00 41 with MAX_WORDS=64: error=1 after the second byte, no imem_we pulses, in_ready=0, cpu_reset stays 1.
- Same image with in_valid toggling 1-0-0-1 randomly: identical writes and values; imem_we pulses exactly once per 4 accepted bytes.
- Header 00 00:
  - Feature off: DONE on the edge after the second byte.
  - Feature on: checksum byte 00 -> done=1; checksum byte 01 -> error=1.
- Assert reset after 6 bytes of the first test's stream: all outputs return to reset values asynchronously; reload with the full stream -> same result as the first test.
- In DONE, pulse start, then send 00 01 00 00 00 00: cpu_reset rises the next cycle; one write of 0x00000000 to addr 0x0; done returns to 1.
